// File: rtl/multiport_register_file.sv
// Multi-read-port register file with per-byte writes, write-through bypass,
// an optional hardwired-zero register 0, and a sequenced bulk-clear engine.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             reg_write,
  input  logic [ADDR_WIDTH-1:0]            write_register,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [DATA_WIDTH/8-1:0]          write_byte_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  input  logic                             clear_start,
  output logic                             clear_busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
  logic                    wr_en;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    for (int k = 0; k < BYTES; k++)
      res[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
    return res;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign clear_busy = busy_q;
  assign wr_en      = reg_write && !busy_q && !is_zero_reg(write_register);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEARING;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEARING: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // The clear sweep owns the array while running; writes arriving then are dropped.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEARING)
      regs_d[cnt_q] = '0;
    else if (wr_en)
      regs_d[write_register] = merge_bytes(regs_q[write_register], write_data, write_byte_enable);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;

    assign addr = read_register[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Bypass merges the in-flight write over the stored bytes so partial writes forward correctly.
    always_comb begin
      if (busy_q)
        rdata = '0;
      else if (is_zero_reg(addr))
        rdata = '0;
      else if (reg_write && (write_register == addr))
        rdata = merge_bytes(regs_q[addr], write_data, write_byte_enable);
      else
        rdata = regs_q[addr];
    end

    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: expected reads are queued when
// inputs are driven and popped when the combinational outputs settle.
module tb_multiport_register_file;
  logic        clock = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [3:0]  write_byte_enable;
  logic [4:0]  rd0, rd1;
  logic [9:0]  read_register;
  logic [63:0] read_data;
  logic [63:0] read_data_nz;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_busy_nz;

  assign read_register = {rd1, rd0};

  always #5 clock = ~clock;

  multiport_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1)) dut (
    .clock(clock), .reset(reset), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .write_byte_enable(write_byte_enable),
    .read_register(read_register), .read_data(read_data),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  multiport_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(0)) dut_nz (
    .clock(clock), .reset(reset), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .write_byte_enable(write_byte_enable),
    .read_register(read_register), .read_data(read_data_nz),
    .clear_start(clear_start), .clear_busy(clear_busy_nz)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [32];
  bit          busy_m;
  int          cnt_m;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (busy_m) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (reg_write && write_register == a) return merge(mem_m[a], write_data, write_byte_enable);
    return mem_m[a];
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
      busy_m = 0;
      cnt_m  = 0;
    end else if (busy_m) begin
      mem_m[cnt_m] = 32'h0;
      if (cnt_m == 31) busy_m = 0;
      cnt_m++;
    end else begin
      if (reg_write && write_register != 5'd0)
        mem_m[write_register] = merge(mem_m[write_register], write_data, write_byte_enable);
      if (clear_start) begin
        busy_m = 1;
        cnt_m  = 0;
      end
    end
  endfunction

  // Inputs are already driven (at negedge); queue expectations, compare, then clock.
  task automatic step(input string tag);
    exp_q.push_back(model_read(rd0));
    exp_q.push_back(model_read(rd1));
    exp_q.push_back({31'h0, busy_m});
    #1;
    chk($sformatf("%s_p0_a%0d", tag, rd0), read_data[31:0], exp_q.pop_front());
    chk($sformatf("%s_p1_a%0d", tag, rd1), read_data[63:32], exp_q.pop_front());
    chk($sformatf("%s_busy", tag), {31'h0, clear_busy}, exp_q.pop_front());
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reg_write = 0; write_register = 0; write_data = 0; write_byte_enable = 0; clear_start = 0;
  endtask

  initial begin
    int nbusy;
    reset = 0; rd0 = 0; rd1 = 0;
    idle_inputs();
    @(negedge clock);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1;

    // Reset contents: every address on both ports reads zero.
    for (int i = 0; i < 16; i++) begin
      rd0 = 5'(i); rd1 = 5'(i + 16);
      step("rst");
    end

    // Full sweep with same-cycle bypass on port 0.
    for (int i = 0; i < 32; i++) begin
      reg_write = 1; write_register = 5'(i); write_data = 32'(3*i + 1); write_byte_enable = 4'hF;
      rd0 = 5'(i); rd1 = 5'((i + 31) % 32);
      #1;
      chk($sformatf("sweep_byp%0d", i), read_data[31:0], (i == 0) ? 32'h0 : 32'(3*i + 1));
      #1;
      step("sweep");
    end
    idle_inputs();
    rd0 = 5'd31; rd1 = 5'd1;
    #1;
    chk("sweep_r31", read_data[31:0], 32'd94);
    chk("sweep_r1", read_data[63:32], 32'd4);
    step("sweep_rd");

    // Byte enables, both bypass and stored.
    reg_write = 1; write_register = 5; write_data = 32'h11223344; write_byte_enable = 4'hF;
    rd0 = 5; rd1 = 5;
    step("be_init");
    write_data = 32'hAABBCCDD; write_byte_enable = 4'b0101;
    #1;
    chk("be_bypass", read_data[31:0], 32'h11BB33DD);
    chk("be_bypass_p1", read_data[63:32], 32'h11BB33DD);
    step("be_wr");
    write_byte_enable = 4'b0000; write_data = 32'hFFFFFFFF;
    step("be_none");
    idle_inputs();
    #1;
    chk("be_stored", read_data[31:0], 32'h11BB33DD);
    step("be_rd");

    // Hardwired zero register versus the ZERO_REG=0 build.
    reg_write = 1; write_register = 0; write_data = 32'hDEADBEEF; write_byte_enable = 4'hF;
    rd0 = 0; rd1 = 0;
    #1;
    chk("zero_byp", read_data[31:0], 32'h0);
    chk("nz_byp", read_data_nz[31:0], 32'hDEADBEEF);
    step("zero_wr");
    idle_inputs();
    #1;
    chk("zero_after", read_data[31:0], 32'h0);
    chk("nz_after", read_data_nz[31:0], 32'hDEADBEEF);
    chk("nz_busy", {31'h0, clear_busy_nz}, 32'h0);
    step("zero_rd");

    // Clear with a simultaneous write, a dropped mid-clear write and a repeated start.
    clear_start = 1; reg_write = 1; write_register = 9; write_data = 32'h99; write_byte_enable = 4'hF;
    rd0 = 9; rd1 = 7;
    step("clr_start");
    nbusy = 0;
    for (int k = 0; k < 36; k++) begin
      idle_inputs();
      rd0 = 5'(k % 32); rd1 = 7;
      if (k == 5) begin
        reg_write = 1; write_register = 7; write_data = 32'h12345678; write_byte_enable = 4'hF;
      end
      if (k == 10) clear_start = 1;
      if (clear_busy) nbusy++;
      step("clr");
    end
    chk("clr_len", 32'(nbusy), 32'd32);
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      rd0 = 5'(i); rd1 = 5'(i + 16);
      step("clr_after");
    end
    rd0 = 7; rd1 = 9;
    #1;
    chk("clr_r7", read_data[31:0], 32'h0);
    chk("clr_r9", read_data[63:32], 32'h0);
    step("clr_r");

    // Reset cutting a clear short.
    reg_write = 1; write_register = 30; write_data = 32'h30; write_byte_enable = 4'hF;
    rd0 = 30; rd1 = 3;
    step("rmc_wr");
    idle_inputs();
    clear_start = 1;
    step("rmc_start");
    clear_start = 0;
    for (int k = 1; k < 10; k++) step("rmc_busy");
    reset = 0;
    step("rmc_reset");
    reset = 1;
    #1;
    chk("rmc_busy_low", {31'h0, clear_busy}, 32'h0);
    chk("rmc_r30", read_data[31:0], 32'h0);
    step("rmc_rel");
    reg_write = 1; write_register = 4; write_data = 32'h44; write_byte_enable = 4'hF;
    rd0 = 4; rd1 = 30;
    step("rmc_wr4");
    idle_inputs();
    #1;
    chk("rmc_r4", read_data[31:0], 32'h44);
    chk("rmc_busy_idle", {31'h0, clear_busy}, 32'h0);
    step("rmc_rd4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
